// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the memory-stage arbiter: FSM states, port ids, request/response
// records and the small helpers used by the arbiter datapath.
package unified_mem_arbiter_pkg;

  localparam int unsigned MEM_ADDR_W = 16;
  localparam int unsigned MEM_DATA_W = 64;
  localparam int unsigned WD_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
    logic                  rw;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0] data;
    logic                  ready;
    logic                  err;
  } mem_rsp_t;

  // A tie goes to the port that did not win last time.
  function automatic port_id_t rr_pick(input logic req_i, input logic req_d,
                                       input port_id_t last);
    if (req_i && req_d) begin
      return (last == PORT_I) ? PORT_D : PORT_I;
    end
    return (req_d && !req_i) ? PORT_D : PORT_I;
  endfunction

  function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_rr_arbiter2.sv
// Two-input round-robin picker; the remembered winner only moves when a grant is taken.
module rr_arbiter2
  import unified_mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     req_ic_i,
  input  logic     req_dc_i,
  input  logic     accept_i,
  output logic     gnt_vld_o,
  output port_id_t gnt_o
);

  port_id_t last_q;

  assign gnt_vld_o = req_ic_i | req_dc_i;
  assign gnt_o     = rr_pick(req_ic_i, req_dc_i, last_q);

  // Reset to D so that I wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= PORT_D;
    end else if (accept_i && gnt_vld_o) begin
      last_q <= gnt_o;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares the single-ported unified memory between the I-cache and D-cache miss paths:
// one transaction at a time, round-robin on contention, watchdog on a silent memory.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_valid,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_rdy,
  output logic              i_err,

  input  logic              d_valid,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic              d_err,

  output logic [DATA_W-1:0] rdata,

  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t        state_q;
  port_id_t          owner_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [WD_W-1:0]   wd_q;
  logic              mem_re_q;
  logic              mem_we_q;
  logic              i_rdy_q;
  logic              i_err_q;
  logic              d_rdy_q;
  logic              d_err_q;

  logic              gnt_vld;
  port_id_t          gnt;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              wd_expired;
  logic              busy_done;
  logic              own_i;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_ic_i  (i_valid),
    .req_dc_i  (d_valid),
    .accept_i  (state_q == IDLE),
    .gnt_vld_o (gnt_vld),
    .gnt_o     (gnt)
  );

  assign sel_rw     = (gnt == PORT_D) ? d_rw    : i_rw;
  assign sel_addr   = (gnt == PORT_D) ? d_addr  : i_addr;
  assign sel_wdata  = (gnt == PORT_D) ? d_wdata : i_wdata;

  // mem_rdy takes priority over the watchdog when both land in the same cycle.
  assign wd_expired = !mem_rdy && (wd_q == WD_LAST);
  assign busy_done  = mem_rdy || wd_expired;
  assign own_i      = (owner_q == PORT_I);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= PORT_I;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wd_q     <= '0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      i_rdy_q  <= 1'b0;
      i_err_q  <= 1'b0;
      d_rdy_q  <= 1'b0;
      d_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            owner_q  <= gnt;
            rw_q     <= sel_rw;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            wd_q     <= '0;
            mem_re_q <= ~sel_rw;
            mem_we_q <= sel_rw;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (busy_done) begin
            rdata_q  <= (mem_rdy && !rw_q) ? mem_rdata : '0;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            i_rdy_q  <= own_i;
            d_rdy_q  <= !own_i;
            i_err_q  <= own_i && wd_expired;
            d_err_q  <= !own_i && wd_expired;
            state_q  <= RESP;
          end else begin
            wd_q <= sat_inc(wd_q);
          end
        end
        RESP: begin
          i_rdy_q <= 1'b0;
          d_rdy_q <= 1'b0;
          i_err_q <= 1'b0;
          d_err_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign i_rdy     = i_rdy_q;
  assign i_err     = i_err_q;
  assign d_rdy     = d_rdy_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench: a transaction-level model decides grants, latencies and responses;
// a separate monitor pops expected responses whenever a ready pulse appears.
module tb_unified_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 64;
  localparam int TO = 10;
  localparam int END_CYC = 3000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0, i_rw = 1'b0, d_valid = 1'b0, d_rw = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] i_wdata = '0, d_wdata = '0;
  logic          i_rdy, i_err, d_rdy, d_err;
  logic [DW-1:0] rdata;
  logic          mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rdy = 1'b0;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_rw(i_rw), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdy(i_rdy), .i_err(i_err),
    .d_valid(d_valid), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_err(d_err),
    .rdata(rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t expq[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string nm, input logic [127:0] act,
                                input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, req);
    end
  endfunction

  // Monitor: every ready pulse must match the oldest expected response, on its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc < 3) continue;
      if (expq.size() > 0 && expq[0].cyc < cyc) begin
        e = expq.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_missing: port %0d expected at cyc %0d, still absent at %0d",
                 e.port, e.cyc, cyc);
      end
      if (i_rdy || d_rdy) begin
        if (expq.size() == 0) begin
          check("rsp_unexpected", {i_rdy, d_rdy}, 2'b00);
        end else begin
          e = expq.pop_front();
          check("rsp", {i_rdy, d_rdy, i_err, d_err, rdata, 32'(cyc)},
                {e.port == 0, e.port == 1, e.port == 0 && e.err, e.port == 1 && e.err,
                 e.data, 32'(e.cyc)});
        end
      end else begin
        check("err_without_rdy", {i_err, d_err}, 2'b00);
      end
    end
  end

  // Stimulus and reference model, one iteration per cycle at the falling edge.
  initial begin
    logic          v[2];
    logic          rw[2];
    logic [AW-1:0] ad[2];
    logic [DW-1:0] wd[2];
    bit            inserv[2];
    int            done_c[2];
    int            last, idle_from, own, lat, r, c, ngrant, rst_c;
    int            bs, be, rdy_c, resp_c;
    bit            active, want_rst, tie_next, tmo;
    logic          trw;
    logic [AW-1:0] tad;
    logic [DW-1:0] twd, tdat;
    exp_t          e;

    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0; rw[p] = 1'b0; ad[p] = '0; wd[p] = '0; inserv[p] = 1'b0; done_c[p] = -1;
    end
    last = 1; idle_from = 0; own = 0; ngrant = 0; rst_c = -1;
    bs = 0; be = -1; rdy_c = -1; resp_c = -1;
    active = 1'b0; want_rst = 1'b0; tie_next = 1'b0;
    trw = 1'b0; tad = '0; twd = '0; tdat = '0;

    while (cyc < END_CYC) begin
      @(negedge clk);
      c = cyc;
      if (c < 3) begin
        rst_n = 1'b0;
        continue;
      end
      if (c == 3) begin
        check("reset_state", {i_rdy, i_err, d_rdy, d_err, mem_re, mem_we, mem_addr,
                              mem_wdata, rdata}, '0);
      end

      // Memory-side view of the current cycle.
      if (active && c >= bs && c <= be)
        check("bus_busy", {mem_re, mem_we, mem_addr, mem_wdata}, {~trw, trw, tad, twd});
      else
        check("bus_idle", {mem_re, mem_we}, 2'b00);

      if (c == 1500) want_rst = 1'b1;

      if (c == rst_c) begin
        rst_n = 1'b0;
        expq.delete();
        active = 1'b0;
        for (int p = 0; p < 2; p++) begin v[p] = 1'b0; inserv[p] = 1'b0; end
        last = 1;
        idle_from = c + 1;
        tie_next = 1'b1;
      end else begin
        rst_n = 1'b1;

        if (active && c > resp_c) begin
          active = 1'b0;
          inserv[own] = 1'b0;
          v[own] = 1'b0;
          done_c[own] = c;
        end

        // The serviced port fiddles with its inputs, sometimes even dropping valid.
        if (active && c >= bs && inserv[own]) begin
          if ($urandom % 3 == 0) begin
            ad[own] = AW'($urandom);
            wd[own] = {$urandom, $urandom};
            rw[own] = 1'($urandom);
          end
          if (v[own] && $urandom % 16 == 0) v[own] = 1'b0;
        end

        for (int p = 0; p < 2; p++) begin
          if (!v[p] && !inserv[p] && c > done_c[p] && c < END_CYC - 100) begin
            if (c == 3) begin
              v[p]  = 1'b1;
              rw[p] = (p == 1);
              ad[p] = (p == 0) ? 16'h0040 : 16'h1234;
              wd[p] = (p == 0) ? 64'h0 : 64'h0123_4567_89AB_CDEF;
            end else if (tie_next || $urandom % 4 == 0) begin
              v[p]  = 1'b1;
              rw[p] = 1'($urandom);
              ad[p] = AW'($urandom);
              wd[p] = {$urandom, $urandom};
            end
          end
        end
        tie_next = 1'b0;

        if (!active && c >= idle_from && (v[0] || v[1])) begin
          if (v[0] && v[1]) own = (last == 0) ? 1 : 0;
          else              own = v[0] ? 0 : 1;
          last = own;
          inserv[own] = 1'b1;
          trw = rw[own]; tad = ad[own]; twd = wd[own];
          tmo = 1'b0;
          if (ngrant == 0)   lat = 4;
          else if (want_rst) lat = 5;
          else begin
            r = $urandom % 8;
            if (r == 0)      begin tmo = 1'b1; lat = 0; end
            else if (r == 1) lat = TO - 1;
            else             lat = $urandom % 7;
          end
          tdat = (ngrant == 0) ? 64'hDEAD_BEEF_0000_0001 : {$urandom, $urandom};
          bs = c + 1;
          if (tmo) begin
            be = c + TO; rdy_c = -1; resp_c = c + TO + 1;
          end else begin
            be = c + 1 + lat; rdy_c = be; resp_c = be + 1;
          end
          e.port = own;
          e.err  = tmo;
          e.data = (tmo || trw) ? '0 : tdat;
          e.cyc  = resp_c;
          expq.push_back(e);
          active = 1'b1;
          ngrant++;
          idle_from = resp_c + 1;
          if (want_rst) begin
            rst_c = c + 2;
            want_rst = 1'b0;
          end
        end
      end

      i_valid = v[0]; i_rw = rw[0]; i_addr = ad[0]; i_wdata = wd[0];
      d_valid = v[1]; d_rw = rw[1]; d_addr = ad[1]; d_wdata = wd[1];
      if (active && c >= bs && c <= be) begin
        mem_rdy   = (c == rdy_c);
        mem_rdata = (c == rdy_c) ? tdat : {$urandom, $urandom};
      end else begin
        mem_rdy   = 1'($urandom);
        mem_rdata = {$urandom, $urandom};
      end
    end

    @(negedge clk);
    check("drained", 128'(expq.size()), 128'(0));
    check("grants_seen", 128'(ngrant > 50), 128'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
